// File: rtl/load_cycle_controller.sv
// rtl/load_cycle_controller.sv - multi-cycle load-word sequencer (decode, address, memory read, write-back)
//
// Ports:
//   clk, reset          : single clock, synchronous active-low reset
//   start, instr        : request and instruction word, accepted only when idle
//   read_reg1/reg_data1 : register-file read port (rs of the captured instruction)
//   reg_write, write_reg, write_data : register-file write port (rt, loaded word)
//   mem_req, mem_addr, mem_ack, mem_rdata : data-memory read handshake
//   busy, done, err, err_code : status; done/err are single-cycle pulses
module load_cycle_controller #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] instr,
    output logic [4:0]  read_reg1,
    input  logic [31:0] reg_data1,
    output logic        reg_write,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    localparam logic [5:0] OP_LW     = 6'b100011;
    // The abort decision is taken in the last permitted MEM cycle, so the
    // comparison is against TIMEOUT-1 (counter value during that cycle).
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [31:0] instr_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [7:0]  wait_cnt;
    logic [1:0]  code_q, code_nx;
    logic [31:0] eff_addr;
    logic        err_raw;
    logic        done_raw;

    // Carry out of bit 31 is dropped, giving the required modulo-2^32 wrap.
    assign eff_addr = reg_data1 + {{16{instr_q[15]}}, instr_q[15:0]};

    always_comb begin
        state_nx = state;
        code_nx  = code_q;
        err_raw  = 1'b0;
        done_raw = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_DECODE;
                    code_nx  = 2'b00;
                end
            end
            S_DECODE: begin
                if (instr_q[31:26] == OP_LW) begin
                    state_nx = S_EXEC;
                end else begin
                    err_raw  = 1'b1;
                    code_nx  = 2'b01;
                    state_nx = S_IDLE;
                end
            end
            S_EXEC: begin
                if (eff_addr[1:0] != 2'b00) begin
                    err_raw  = 1'b1;
                    code_nx  = 2'b10;
                    state_nx = S_IDLE;
                end else begin
                    state_nx = S_MEM;
                end
            end
            S_MEM: begin
                // An ack in the final permitted cycle still wins over the abort.
                if (mem_ack) begin
                    state_nx = S_WB;
                end else if (wait_cnt == LAST_WAIT) begin
                    err_raw  = 1'b1;
                    code_nx  = 2'b11;
                    state_nx = S_IDLE;
                end
            end
            S_WB: begin
                done_raw = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            instr_q  <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            wait_cnt <= '0;
            code_q   <= 2'b00;
        end else begin
            state  <= state_nx;
            code_q <= code_nx;
            if (state == S_IDLE && start) begin
                instr_q <= instr;
            end
            if (state == S_EXEC) begin
                addr_q   <= eff_addr;
                wait_cnt <= '0;
            end
            if (state == S_MEM) begin
                if (mem_ack) begin
                    data_q <= mem_rdata;
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
            end
        end
    end

    // Strobes are qualified with reset so nothing fires in a cycle where
    // reset is asserted, even before the state register has been cleared.
    assign read_reg1  = instr_q[25:21];
    assign write_reg  = instr_q[20:16];
    assign write_data = data_q;
    assign mem_addr   = addr_q;
    assign mem_req    = reset && (state == S_MEM);
    assign reg_write  = reset && (state == S_WB) && (instr_q[20:16] != 5'd0);
    assign done       = reset && done_raw;
    assign err        = reset && err_raw;
    assign busy       = (state != S_IDLE);
    assign err_code   = code_q;

endmodule

// File: tb/tb_load_cycle_controller.sv
// tb/tb_load_cycle_controller.sv - self-checking bench for load_cycle_controller
module tb_load_cycle_controller;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] instr;
    logic [4:0]  read_reg1;
    logic [31:0] reg_data1;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    logic [31:0] regs [32];
    assign reg_data1 = regs[read_reg1];

    int checks   = 0;
    int failures = 0;

    load_cycle_controller #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .instr(instr),
        .read_reg1(read_reg1), .reg_data1(reg_data1),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rdata;
        int          ack_at;    // MEM cycle (1-based) carrying the ack; 0 = never
        logic [31:0] mrdata;
        int          exp_code;
        logic [31:0] exp_addr;
        int          exp_end;   // cycle after acceptance with done/err
        int          exp_req;   // number of mem_req cycles
        int          exp_rw;    // number of reg_write cycles
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Reference outcome from the load rules, in transaction-level terms.
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        logic [31:0] a;
        int          imm_s;
        r        = v;
        imm_s    = int'($signed(v.instr[15:0]));
        a        = v.rdata + 32'(imm_s);
        r.exp_addr = a;
        r.exp_req  = 0;
        r.exp_rw   = 0;
        if (v.instr[31:26] != 6'd35) begin
            r.exp_code = 1; r.exp_end = 1;
        end else if (a % 4 != 0) begin
            r.exp_code = 2; r.exp_end = 2;
        end else if (v.ack_at < 1 || v.ack_at > TO) begin
            r.exp_code = 3; r.exp_end = 2 + TO; r.exp_req = TO;
        end else begin
            r.exp_code = 0; r.exp_end = 3 + v.ack_at; r.exp_req = v.ack_at;
            r.exp_rw   = (v.instr[20:16] != 0) ? 1 : 0;
        end
        return r;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        int          req_cnt, rw_cnt, end_cyc, is_err, bad_addr, bad_busy;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        req_cnt = 0; rw_cnt = 0; end_cyc = 0; is_err = 0; bad_addr = 0; bad_busy = 0;
        wreg = '0; wdata = '0;
        regs[v.instr[25:21]] = v.rdata;
        @(negedge clk);
        start = 1'b1; instr = v.instr; mem_ack = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0; instr = $urandom;
        for (int c = 1; c <= 40 && end_cyc == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk({tag, " read_reg1"}, 32'(read_reg1), 32'(v.instr[25:21]));
                chk({tag, " err_code_cleared"}, 32'(err_code), 32'd0);
            end
            if (mem_req) begin
                req_cnt++;
                if (mem_addr !== v.exp_addr) bad_addr++;
                mem_ack   = (req_cnt == v.ack_at);
                mem_rdata = mem_ack ? v.mrdata : $urandom;
            end else begin
                mem_ack   = 1'($urandom % 2);
                mem_rdata = $urandom;
            end
            #1;
            if (!busy) bad_busy++;
            if (reg_write) begin
                rw_cnt++; wreg = write_reg; wdata = write_data;
            end
            if (done) begin end_cyc = c; is_err = 0; end
            if (err)  begin end_cyc = c; is_err = 1; end
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk({tag, " end_cycle"}, 32'(end_cyc), 32'(v.exp_end));
        chk({tag, " err_vs_done"}, 32'(is_err), 32'(v.exp_code != 0));
        chk({tag, " req_cycles"}, 32'(req_cnt), 32'(v.exp_req));
        chk({tag, " addr_errors"}, 32'(bad_addr), 32'd0);
        chk({tag, " busy_gaps"}, 32'(bad_busy), 32'd0);
        chk({tag, " write_count"}, 32'(rw_cnt), 32'(v.exp_rw));
        if (v.exp_rw == 1) begin
            chk({tag, " write_reg"}, 32'(wreg), 32'(v.instr[20:16]));
            chk({tag, " write_data"}, wdata, v.mrdata);
        end
        chk({tag, " err_code"}, 32'(err_code), 32'(v.exp_code));
        chk({tag, " idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [9];
        vec_t v;
        int   stray, waited;

        for (int i = 0; i < 32; i++) regs[i] = 32'(i * 16);
        reset = 1'b0; start = 1'b0; instr = '0; mem_ack = 1'b0; mem_rdata = '0;

        // Reset state, sampled while reset is still asserted.
        repeat (3) @(negedge clk);
        chk("rst busy", 32'(busy), 0);
        chk("rst strobes", {28'd0, done, err, reg_write, mem_req}, 0);
        chk("rst err_code", 32'(err_code), 0);
        chk("rst regs", {22'd0, read_reg1, write_reg}, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst write_data", write_data, 0);
        reset = 1'b1;

        tbl[0] = '{mk(6'd35, 5'd2, 5'd5, 16'h0008), 32'h100, 1, 32'hDEADBEEF, 0, 32'h108, 4, 1, 1};
        tbl[1] = '{mk(6'd35, 5'd3, 5'd7, 16'hFFFC), 32'h0, 1, 32'h12345678, 0, 32'hFFFFFFFC, 4, 1, 1};
        tbl[2] = '{mk(6'd0, 5'd4, 5'd6, 16'h0010), 32'h40, 1, 32'h0, 1, 32'h50, 1, 0, 0};
        tbl[3] = '{mk(6'd35, 5'd9, 5'd10, 16'h0000), 32'h101, 1, 32'h0, 2, 32'h101, 2, 0, 0};
        tbl[4] = '{mk(6'd35, 5'd2, 5'd5, 16'h0008), 32'h100, 0, 32'h0, 3, 32'h108, 6, 4, 0};
        tbl[5] = '{mk(6'd35, 5'd2, 5'd5, 16'h0008), 32'h100, 3, 32'hCAFEF00D, 0, 32'h108, 6, 3, 1};
        tbl[6] = '{mk(6'd35, 5'd1, 5'd0, 16'h0004), 32'h1000, 2, 32'hAAAA5555, 0, 32'h1004, 5, 2, 0};
        tbl[7] = '{mk(6'd35, 5'd6, 5'd8, 16'hFFF8), 32'h20, 4, 32'h11112222, 0, 32'h18, 7, 4, 1};
        tbl[8] = '{mk(6'd35, 5'd6, 5'd8, 16'h0000), 32'h20, 5, 32'h0, 3, 32'h20, 6, 4, 0};
        for (int i = 0; i < 9; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // err_code holds through idle cycles after an abort.
        run_txn(tbl[3], "hold");
        repeat (4) @(negedge clk);
        chk("err_code hold", 32'(err_code), 32'd2);

        // Randomized transactions against the reference model.
        for (int i = 0; i < 40; i++) begin
            v.instr  = mk(($urandom % 10 < 7) ? 6'd35 : 6'($urandom),
                          5'($urandom), 5'($urandom), 16'($urandom));
            if ($urandom % 5 != 0) v.instr[1:0] = 2'b00;
            v.rdata  = $urandom;
            if ($urandom % 5 != 0) v.rdata[1:0] = 2'b00;
            v.ack_at = int'($urandom % 7);
            v.mrdata = $urandom;
            v = model(v);
            run_txn(v, $sformatf("rnd%0d", i));
        end

        // start held through WB: ignored there, accepted in the following IDLE cycle.
        regs[2] = 32'h100;
        @(negedge clk);
        start = 1'b1; instr = mk(6'd35, 5'd2, 5'd5, 16'h0008);
        @(posedge clk);
        waited = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            mem_ack = mem_req;
            mem_rdata = 32'h5A5A0001;
            #1;
            if (done) begin waited = c; break; end
        end
        chk("wb_start done_cycle", 32'(waited), 32'd4);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("wb_start ignored", 32'(busy), 32'd0);
        @(negedge clk);
        #1;
        chk("wb_start next_accept", 32'(busy), 32'd1);
        start = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Reset in the middle of MEM; later acks must be ignored.
        regs[1] = 32'h200;
        @(negedge clk);
        start = 1'b1; instr = mk(6'd35, 5'd1, 5'd3, 16'h0000); mem_ack = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        waited = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            #1;
            if (mem_req) begin waited = c; break; end
        end
        chk("mreset reached_mem", 32'(waited), 32'd3);
        reset = 1'b0;
        #1;
        chk("mreset req_gated", 32'(mem_req), 32'd0);
        @(posedge clk);
        #1;
        chk("mreset busy", 32'(busy), 32'd0);
        chk("mreset mem_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        stray = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            if (busy || reg_write || done || err || mem_req) stray++;
        end
        chk("mreset late_ack_ignored", 32'(stray), 32'd0);
        mem_ack = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_cycle_controller.md
LOAD_CYCLE_CONTROLLER -- requirements
Module: load_cycle_controller

Interface
REQ-001 Parameter: TIMEOUT, 255, max MEM-state cycles without mem_ack before abort (1..255).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising clk.
REQ-004 start  input  1  request to execute instr; honoured only in IDLE.
REQ-005 instr  input  32  instruction word; [31:26] opcode, [25:21] rs, [20:16] rt, [15:0] imm.
REQ-006 read_reg1  output  5  register-file read address (rs of captured instr).
REQ-007 reg_data1  input  32  register-file read data for read_reg1, combinational.
REQ-008 reg_write  output  1  register-file write enable.
REQ-009 write_reg  output  5  register-file write address (rt).
REQ-010 write_data  output  32  register-file write data (loaded word).
REQ-011 mem_req  output  1  data-memory read request.
REQ-012 mem_addr  output  32  data-memory byte address.
REQ-013 mem_ack  input  1  memory accept/data-valid, same cycle as mem_rdata.
REQ-014 mem_rdata  input  32  memory read data.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 done  output  1  one-cycle pulse on successful completion.
REQ-017 err  output  1  one-cycle pulse on abort.
REQ-018 err_code  output  2  00 none, 01 illegal opcode, 10 misaligned address, 11 memory timeout.

Function
REQ-019 FSM states SHALL be IDLE, DECODE, EXEC, MEM, WB.
REQ-020 IDLE: start=1 SHALL capture instr into instr_q, clear err_code to 00, go to DECODE; start in any other state SHALL be ignored.
REQ-021 read_reg1 SHALL equal instr_q[25:21] in every state; 0 after reset.
REQ-022 DECODE: opcode 6'b100011 SHALL go to EXEC; any other opcode SHALL pulse err, set err_code=01, go to IDLE.
REQ-023 EXEC: addr_q SHALL load reg_data1 + sign-extended imm, modulo 2^32 (carry discarded).
REQ-024 EXEC: if computed address [1:0] != 00, SHALL pulse err, set err_code=10, go to IDLE, never assert mem_req.
REQ-025 EXEC otherwise SHALL go to MEM with wait counter cleared.
REQ-026 MEM: mem_req SHALL be 1 and mem_addr SHALL hold addr_q stable until mem_ack or abort.
REQ-027 MEM with mem_ack=1 SHALL capture mem_rdata into data_q and go to WB the next cycle.
REQ-028 MEM with mem_ack=0 SHALL increment wait counter (8-bit); when counter reaches TIMEOUT with no ack, SHALL deassert mem_req next cycle, pulse err, set err_code=11, go to IDLE.
REQ-029 mem_ack outside MEM SHALL be ignored.
REQ-030 WB: write_reg=instr_q[20:16], write_data=data_q, reg_write=1 for exactly one cycle; reg_write SHALL stay 0 if rt=0.
REQ-031 WB: done SHALL pulse in the same cycle as the write (also when rt=0), then go to IDLE.
REQ-032 Latency: start accepted at edge N, mem_ack in first MEM cycle -> done/reg_write high in cycle N+4; each stalled MEM cycle adds one.
REQ-033 reg_write, mem_req, done, err SHALL be 0 in all states not named above.
REQ-034 err_code SHALL hold its value until the next accepted start or reset.
REQ-035 A start arriving in the WB cycle SHALL be ignored; earliest acceptance is the first IDLE cycle.

Reset
REQ-036 reset=0 at a clk edge SHALL force IDLE from any state, including mid-MEM, with mem_req deasserted from that edge.
REQ-037 Reset values: busy, done, err, reg_write, mem_req = 0; err_code=00; read_reg1, write_reg = 0; mem_addr, write_data = 0; instr_q, addr_q, data_q, counter = 0.
REQ-038 No register-file write or memory request SHALL occur in a cycle with reset=0.

Verification
REQ-039 lw rt=5, rs=2, imm=0x0008, reg_data1=0x100, ack first MEM cycle with 0xDEADBEEF -> mem_addr=0x108, reg_write=1, write_reg=5, write_data=0xDEADBEEF, done at N+4.
REQ-040 imm=0xFFFC, reg_data1=0x0 -> mem_addr=0xFFFFFFFC (wrap), completes normally.
REQ-041 opcode 6'b000000 -> err pulse at DECODE, err_code=01, no mem_req, no reg_write.
REQ-042 reg_data1=0x101, imm=0 -> err_code=10, mem_req never high.
REQ-043 TIMEOUT=4, mem_ack held 0 -> mem_req high 4 cycles then low, err_code=11; repeat with ack in 3rd MEM cycle -> success, done 2 cycles later than REQ-039 timing.
REQ-044 reset=0 during MEM -> next cycle busy=0, mem_req=0; later ack ignored; rt=0 load -> done=1, reg_write=0.
